serial_ripple_subtractor: RTL and testbench
===========================================

// Module: serial_ripple_subtractor
// PURPOSE
//  Multi-cycle ripple subtractor: computes diff = a - b - bin over WIDTH bits, DIGIT bits per clock,
//  through a borrow chain of full_subtractor cells. Inverse-direction companion of the ripple
//  carry adder. Sits between an upstream operand producer and a downstream consumer via valid/ready.
// PARAMETERS
//  WIDTH  8  operand/result width in bits; must be a multiple of DIGIT
//  DIGIT  1  bits processed per cycle (1..WIDTH); latency = WIDTH/DIGIT cycles
// PORTS
//  clk_i        in   1      clock, rising-edge
//  rst_ni       in   1      asynchronous, active-low reset
//  in_valid_i   in   1      operands valid
//  in_ready_o   out  1      block can accept operands
//  a_i          in   WIDTH  minuend
//  b_i          in   WIDTH  subtrahend
//  bin_i        in   1      borrow-in
//  out_valid_o  out  1      result valid
//  out_ready_i  in   1      consumer accepts result
//  diff_o       out  WIDTH  a - b - bin, modulo 2^WIDTH
//  bout_o       out  1      borrow-out (1 when unsigned a < b + bin)
//  ovf_o        out  1      signed two's-complement overflow
// BEHAVIOUR
//  - One clock (clk_i); reset asynchronous, active-low (rst_ni). All state/outputs clear on reset.
//  - Reset values: in_ready_o=1, out_valid_o=0, diff_o=0, bout_o=0, ovf_o=0; FSM=IDLE; count=0.
//  - FSM states: IDLE, RUN, DONE.
//    IDLE: in_ready_o=1. in_valid_i&in_ready_o -> latch a,b into shift regs, borrow<=bin_i,
//          count<=0, -> RUN. Inputs ignored otherwise.
//    RUN:  in_ready_o=0. Each cycle feed low DIGIT bits of a,b and borrow reg into DIGIT chained
//          full_subtractor cells; shift DIGIT diff bits into result reg from MSB side; borrow reg <=
//          chain borrow-out; count++. On final digit (count==WIDTH/DIGIT-1) -> DONE.
//    DONE: out_valid_o=1, diff_o/bout_o/ovf_o stable. out_valid_o&out_ready_i -> IDLE.
//  - Latency: accept in cycle N -> out_valid_o high from cycle N+WIDTH/DIGIT+1 (registered).
//  - ovf_o = (a[MSB]^b[MSB]) & (a[MSB]^diff[MSB]); a/b MSBs captured at accept.
//  - bout_o = borrow out of the MSB cell; bin is included in both bout_o and ovf_o.
//  - Backpressure: DONE holds results indefinitely while out_ready_i=0; no new accept.
//  - No same-cycle handover: DONE->IDLE consumes a cycle; in_ready_o rises the cycle after handoff.
//  - in_valid_i/a_i/b_i changes during RUN/DONE have no effect.
//  - Reset asserted mid-RUN or mid-DONE: immediate abort, result discarded, reset values restored.
//  - Degenerate DIGIT==WIDTH: single RUN cycle.
//  - full_subtractor cell: d = x^y^bi; bo = (~x&y) | (~(x^y)&bi).
// STRUCTURE
//  - Package ripple_sub_pkg: typedef enum logic[1:0] {IDLE, RUN, DONE} sub_state_e;
//    function clog2-based count width helper.
//  - Sub-module full_subtractor (a_i, b_i, bin_i, diff_o, bout_o), instantiated DIGIT times
//    via generate; top holds FSM, shift regs, counter, borrow reg, result reg.
//  - Elaboration check: WIDTH % DIGIT == 0, else $fatal.
// TESTING
//  1. WIDTH=8,DIGIT=1: a=8'h05,b=8'h03,bin=0 -> diff=8'h02,bout=0,ovf=0, out_valid 9 cycles after accept.
//  2. a=8'h00,b=8'h01,bin=0 -> diff=8'hFF,bout=1,ovf=0; a=8'h80,b=8'h01 -> diff=8'h7F,bout=0,ovf=1.
//  3. a=8'h10,b=8'h0F,bin=1 -> diff=8'h00,bout=0; a=8'h00,b=8'hFF,bin=1 -> diff=8'h00,bout=1.
//  4. Backpressure: out_ready_i=0 for 5 cycles in DONE -> outputs stable, in_ready_o=0; release
//     -> one handshake, in_ready_o=1 next cycle.
//  5. rst_ni low 3 cycles into RUN -> all outputs reset values same cycle; next op result correct.
//  6. DIGIT in {2,4,8}: 1000 random a,b,bin vs reference model; latency = 8/DIGIT+1.

Source files
------------

// File: rtl/serial_ripple_subtractor_pkg.sv
// Shared types and helpers for the digit-serial ripple subtractor.
package ripple_sub_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } sub_state_e;

    // Counter width for n digit steps; never narrower than one bit.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/serial_ripple_subtractor_full_subtractor.sv
// One-bit full subtractor cell: d = x - y - bi with borrow-out.
module full_subtractor (
    input  logic a_i,
    input  logic b_i,
    input  logic bin_i,
    output logic diff_o,
    output logic bout_o
);

    assign diff_o = a_i ^ b_i ^ bin_i;
    assign bout_o = (~a_i & b_i) | (~(a_i ^ b_i) & bin_i);

endmodule

// File: rtl/serial_ripple_subtractor.sv
// Digit-serial subtractor: diff = a - b - bin, DIGIT bits per clock through a
// chain of full_subtractor cells, with valid/ready handshakes on both sides.
import ripple_sub_pkg::*;

module serial_ripple_subtractor #(
    parameter int WIDTH = 8,
    parameter int DIGIT = 1
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             bin_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [WIDTH-1:0] diff_o,
    output logic             bout_o,
    output logic             ovf_o
);

    localparam int NDIG = (DIGIT > 0) ? (WIDTH / DIGIT) : 1;
    localparam int CW   = cnt_width(NDIG);
    localparam logic [CW-1:0] LAST = CW'(NDIG - 1);

    if (DIGIT < 1 || DIGIT > WIDTH) begin : g_bad_digit
        $fatal(1, "DIGIT must lie in 1..WIDTH");
    end else if ((WIDTH % DIGIT) != 0) begin : g_bad_mult
        $fatal(1, "WIDTH must be a multiple of DIGIT");
    end

    sub_state_e         state_q, state_d;
    logic [WIDTH-1:0]   a_q, a_d, b_q, b_d, res_q, res_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic               borrow_q, borrow_d;
    logic               a_msb_q, a_msb_d, b_msb_q, b_msb_d;
    logic               bout_q, bout_d, ovf_q, ovf_d;
    logic               in_ready_q, in_ready_d, out_valid_q, out_valid_d;

    logic [DIGIT:0]         chain_s;
    logic [DIGIT-1:0]       dig_s;
    logic [WIDTH+DIGIT-1:0] cat_s;

    assign chain_s[0] = borrow_q;

    for (genvar i = 0; i < DIGIT; i++) begin : g_cell
        full_subtractor u_fs (
            .a_i    (a_q[i]),
            .b_i    (b_q[i]),
            .bin_i  (chain_s[i]),
            .diff_o (dig_s[i]),
            .bout_o (chain_s[i+1])
        );
    end

    // New digit enters at the MSB so the last digit lands in the top bits.
    assign cat_s = {dig_s, res_q};

    // Next-state logic for the handshake FSM and the serial datapath.
    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        res_d    = res_q;
        cnt_d    = cnt_q;
        borrow_d = borrow_q;
        a_msb_d  = a_msb_q;
        b_msb_d  = b_msb_q;
        bout_d   = bout_q;
        ovf_d    = ovf_q;
        case (state_q)
            IDLE: begin
                if (in_valid_i && in_ready_q) begin
                    a_d      = a_i;
                    b_d      = b_i;
                    borrow_d = bin_i;
                    cnt_d    = '0;
                    a_msb_d  = a_i[WIDTH-1];
                    b_msb_d  = b_i[WIDTH-1];
                    bout_d   = 1'b0;
                    ovf_d    = 1'b0;
                    state_d  = RUN;
                end else begin
                    state_d  = IDLE;
                end
            end
            RUN: begin
                a_d      = a_q >> DIGIT;
                b_d      = b_q >> DIGIT;
                res_d    = cat_s[WIDTH+DIGIT-1:DIGIT];
                borrow_d = chain_s[DIGIT];
                cnt_d    = cnt_q + CW'(1);
                if (cnt_q == LAST) begin
                    bout_d  = chain_s[DIGIT];
                    ovf_d   = (a_msb_q ^ b_msb_q) & (a_msb_q ^ dig_s[DIGIT-1]);
                    state_d = DONE;
                end else begin
                    state_d = RUN;
                end
            end
            DONE: begin
                if (out_ready_i) begin
                    state_d = IDLE;
                end else begin
                    state_d = DONE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        in_ready_d  = (state_d == IDLE);
        out_valid_d = (state_d == DONE);
    end

    // State and output registers with asynchronous active-low reset.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= IDLE;
            a_q         <= '0;
            b_q         <= '0;
            res_q       <= '0;
            cnt_q       <= '0;
            borrow_q    <= 1'b0;
            a_msb_q     <= 1'b0;
            b_msb_q     <= 1'b0;
            bout_q      <= 1'b0;
            ovf_q       <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            a_q         <= a_d;
            b_q         <= b_d;
            res_q       <= res_d;
            cnt_q       <= cnt_d;
            borrow_q    <= borrow_d;
            a_msb_q     <= a_msb_d;
            b_msb_q     <= b_msb_d;
            bout_q      <= bout_d;
            ovf_q       <= ovf_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign in_ready_o  = in_ready_q;
    assign out_valid_o = out_valid_q;
    assign diff_o      = res_q;
    assign bout_o      = bout_q;
    assign ovf_o       = ovf_q;

endmodule

// File: tb/tb_serial_ripple_subtractor.sv
// Scoreboard bench: three instances (DIGIT 1, 2, 8) share stimulus; a monitor
// pops expected results per instance on each output handshake.
module tb_serial_ripple_subtractor;

    typedef struct {
        logic [7:0] d;
        logic       bo;
        logic       ov;
        int         acc;
    } exp_t;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic [7:0] a, b;
    logic       bin;
    logic       out_ready;
    logic [2:0] in_ready, out_valid, bout, ovf;
    logic [7:0] diff [3];

    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;
    exp_t exp_q [3][$];

    for (genvar g = 0; g < 3; g++) begin : g_dut
        localparam int D = (g == 0) ? 1 : ((g == 1) ? 2 : 8);
        serial_ripple_subtractor #(.WIDTH(8), .DIGIT(D)) u_dut (
            .clk_i       (clk),
            .rst_ni      (rst_n),
            .in_valid_i  (in_valid),
            .in_ready_o  (in_ready[g]),
            .a_i         (a),
            .b_i         (b),
            .bin_i       (bin),
            .out_valid_o (out_valid[g]),
            .out_ready_i (out_ready),
            .diff_o      (diff[g]),
            .bout_o      (bout[g]),
            .ovf_o       (ovf[g])
        );
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic int ndig(input int g);
        return (g == 0) ? 8 : ((g == 1) ? 4 : 1);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic issue(input logic [7:0] ia, input logic [7:0] ib, input logic ibin,
                         input logic [7:0] ed, input logic eb, input logic eo, input bit push);
        bit   ok = 0;
        exp_t e;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (&in_ready) begin
                ok = 1;
                break;
            end
        end
        chk("issue_ready_wait", {31'd0, ok}, 32'd1);
        if (ok) begin
            a = ia; b = ib; bin = ibin; in_valid = 1'b1;
            e.d = ed; e.bo = eb; e.ov = eo; e.acc = cyc;
            if (push) begin
                for (int g = 0; g < 3; g++) exp_q[g].push_back(e);
            end
            @(posedge clk);
            #1;
            in_valid = 1'b0;
        end
    endtask

    task automatic drain();
        bit done = 0;
        for (int k = 0; k < 300; k++) begin
            @(negedge clk);
            if (exp_q[0].size() == 0 && exp_q[1].size() == 0 && exp_q[2].size() == 0 && (&in_ready)) begin
                done = 1;
                break;
            end
        end
        chk("drain", {31'd0, done}, 32'd1);
    endtask

    task automatic check_reset_vals(input string tag);
        for (int g = 0; g < 3; g++) begin
            chk($sformatf("%s_dut%0d", tag, g),
                {20'd0, in_ready[g], out_valid[g], diff[g], bout[g], ovf[g]},
                {20'd0, 12'b1_0_00000000_0_0});
        end
    endtask

    // Monitor: latency on rising out_valid, result compare on handshake.
    initial begin : monitor
        bit   prev [3];
        exp_t e;
        for (int g = 0; g < 3; g++) prev[g] = 1'b0;
        forever begin
            @(negedge clk);
            for (int g = 0; g < 3; g++) begin
                if (out_valid[g] && !prev[g] && exp_q[g].size() > 0) begin
                    chk($sformatf("latency_dut%0d", g), cyc, exp_q[g][0].acc + ndig(g) + 1);
                end
                if (out_valid[g] && out_ready) begin
                    if (exp_q[g].size() == 0) begin
                        chk($sformatf("unexpected_out_dut%0d", g), {31'd0, out_valid[g]}, 32'd0);
                    end else begin
                        e = exp_q[g].pop_front();
                        chk($sformatf("diff_dut%0d", g), {24'd0, diff[g]}, {24'd0, e.d});
                        chk($sformatf("bout_dut%0d", g), {31'd0, bout[g]}, {31'd0, e.bo});
                        chk($sformatf("ovf_dut%0d", g),  {31'd0, ovf[g]},  {31'd0, e.ov});
                    end
                end
                prev[g] = out_valid[g];
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    logic [7:0] tv_a  [8] = '{8'h05, 8'h00, 8'h80, 8'h10, 8'h00, 8'h7F, 8'hFF, 8'hA5};
    logic [7:0] tv_b  [8] = '{8'h03, 8'h01, 8'h01, 8'h0F, 8'hFF, 8'hFF, 8'hFF, 8'h5A};
    logic       tv_bi [8] = '{1'b0,  1'b0,  1'b0,  1'b1,  1'b1,  1'b0,  1'b1,  1'b0};
    logic [7:0] tv_d  [8] = '{8'h02, 8'hFF, 8'h7F, 8'h00, 8'h00, 8'h80, 8'hFF, 8'h4B};
    logic       tv_bo [8] = '{1'b0,  1'b1,  1'b0,  1'b0,  1'b1,  1'b1,  1'b1,  1'b0};
    logic       tv_ov [8] = '{1'b0,  1'b0,  1'b1,  1'b0,  1'b0,  1'b1,  1'b0,  1'b1};

    initial begin : main
        logic [7:0] ra, rb, ed;
        logic       rbin;
        logic [8:0] full;
        bit         seen;

        rst_n = 1'b1; in_valid = 1'b0; a = 8'd0; b = 8'd0; bin = 1'b0; out_ready = 1'b1;
        #2 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        check_reset_vals("reset_state");
        rst_n = 1'b1;

        for (int i = 0; i < 8; i++) begin
            issue(tv_a[i], tv_b[i], tv_bi[i], tv_d[i], tv_bo[i], tv_ov[i], 1'b1);
        end

        for (int i = 0; i < 24; i++) begin
            ra   = 8'($urandom_range(0, 255));
            rb   = 8'($urandom_range(0, 255));
            rbin = 1'($urandom_range(0, 1));
            full = {1'b0, ra} - {1'b0, rb} - {8'd0, rbin};
            ed   = full[7:0];
            issue(ra, rb, rbin, ed, full[8], (ra[7] ^ rb[7]) & (ra[7] ^ ed[7]), 1'b1);
        end
        drain();

        // Backpressure: hold the result in DONE for five cycles.
        @(posedge clk); #1 out_ready = 1'b0;
        issue(8'h3C, 8'h1E, 1'b0, 8'h1E, 1'b0, 1'b0, 1'b1);
        seen = 0;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (out_valid[0]) begin
                seen = 1;
                break;
            end
        end
        chk("bp_valid_wait", {31'd0, seen}, 32'd1);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("bp_out_valid", {31'd0, out_valid[0]}, 32'd1);
            chk("bp_in_ready",  {31'd0, in_ready[0]},  32'd0);
            chk("bp_diff_hold", {24'd0, diff[0]},      32'h1E);
        end
        @(posedge clk); #1 out_ready = 1'b1;
        @(negedge clk);
        chk("bp_handoff_in_ready", {31'd0, in_ready[0]}, 32'd0);
        @(negedge clk);
        chk("bp_after_valid",    {31'd0, out_valid[0]}, 32'd0);
        chk("bp_after_in_ready", {31'd0, in_ready[0]},  32'd1);
        drain();

        // Reset a few cycles into RUN (DIGIT=8 instance is already in DONE).
        @(posedge clk); #1 out_ready = 1'b0;
        issue(8'h55, 8'h22, 1'b0, 8'h33, 1'b0, 1'b0, 1'b0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_reset_vals("mid_run_reset");
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1 out_ready = 1'b1;

        issue(8'h05, 8'h07, 1'b0, 8'hFE, 1'b1, 1'b0, 1'b1);
        issue(8'h80, 8'h00, 1'b1, 8'h7F, 1'b0, 1'b1, 1'b1);
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
